fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write arbiter sharing one 32x32 FIFO between NUM_REQ producers.
//   Grants one producer at a time and limits each grant to MAX_BURST words.
//   Drives the FIFO write port (w_en / data_in) and backs off while full is high.
//   Sits between the producer blocks and the FIFO; the FIFO read side is untouched.
// PARAMETERS
//   NUM_REQ    4   number of requesters (2..8)
//   DATA_W     32  word width; matches FIFO data_in
//   MAX_BURST  4   max words per grant (1..16)
// PORTS
//   clk         in   1                clock; all state updates on posedge
//   rst         in   1                synchronous, active-low reset
//   req         in   NUM_REQ          req[i]=1: producer i has a word on req_data slice i
//   req_data    in   NUM_REQ*DATA_W   producer i word in bits [i*DATA_W +: DATA_W]
//   ack         out  NUM_REQ          one-hot; ack[i]=1: word i written this edge
//   fifo_full   in   1                FIFO full flag
//   fifo_w_en   out  1                FIFO write enable
//   fifo_data   out  DATA_W           FIFO write data
//   grant_valid out  1                1 while in OWN state
//   grant_id    out  $clog2(NUM_REQ)  current/last owner index
// BEHAVIOUR
//   - Reset (rst==0 at posedge):
//     - state=IDLE, burst_cnt=0, last_owner=NUM_REQ-1, grant_id=0.
//     - Outputs ack, fifo_w_en, fifo_data and grant_valid are 0 from that edge on.
//     - Reset mid-burst drops the grant immediately; the FIFO gets no partial write.
//   - FSM with two states, IDLE and OWN.
//   - IDLE:
//     - If any req bit is set, pick the first set bit searching from last_owner+1, wrapping mod NUM_REQ.
//     - Register that index into grant_id, clear burst_cnt, go to OWN.
//     - No write happens in IDLE, so each grant costs exactly 1 arbitration bubble.
//   - OWN, write condition: write = req[grant_id] & ~fifo_full.
//     - fifo_w_en = write; ack[grant_id] = write (combinational, same cycle).
//     - fifo_data = selected slice when write=1, else 0.
//   - OWN, on write: burst_cnt++.
//     - If burst_cnt == MAX_BURST-1 at that edge: go to IDLE, last_owner = grant_id.
//   - OWN, req[grant_id]==0: no write; go to IDLE, last_owner = grant_id (release).
//   - OWN, fifo_full==1 with req high: stall.
//     - No w_en, no ack, burst_cnt frozen, state held.
//     - Arbiter never asserts fifo_w_en while fifo_full=1.
//   - Producer rule: hold req_data stable while req is high.
//     - A word is consumed only on an edge where ack is high.
//     - A producer may drop req at any time.
//   - Requests from non-owners during OWN are ignored until the next IDLE.
//   - grant_id holds its last value in IDLE; grant_valid = (state==OWN).
//   - Sustained throughput: MAX_BURST words per MAX_BURST+1 cycles with no full stalls.
// TESTING
//   1. Reset: rst=0 for 2 cycles, req=4'b1111 -> ack=0, fifo_w_en=0, grant_valid=0;
//      after release, first grant_id=0.
//   2. Single producer: req[1] held, words 0xA0..0xA5, MAX_BURST=4
//      -> 1 bubble, 4 writes A0..A3, 1 bubble, 2 writes A4,A5; grant_id=1 throughout.
//   3. All 4 req held, 4 words each -> grants 0,1,2,3 in order;
//      FIFO receives 16 words grouped by producer; w_en duty 4 of 5 cycles.
//   4. fifo_full=1 for 3 cycles after 2nd word of burst -> no w_en/ack in those cycles;
//      burst resumes and ends after 2 more words.
//   5. Owner 2 drops req after 2 words while req[0],req[3] pending
//      -> IDLE next cycle, next grant_id=3, then 0.
//   6. rst=0 mid-burst of owner 1 with req=4'b1111 held
//      -> no write in reset cycle; next grant_id=0, not 2.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets several producers share one FIFO write
// port. One producer owns the port at a time, for at most MAX_BURST words.
// Every grant starts with a single arbitration bubble in IDLE. The arbiter
// holds off while the FIFO reports full.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   input  logic                      fifo_full,
   output logic                      fifo_w_en,
   output logic [DATA_W-1:0]         fifo_data,
   output logic                      grant_valid,
   output logic [ID_W-1:0]           grant_id
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]  RESET_OWNER = ID_W'(NUM_REQ - 1);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  burst_cnt, burst_cnt_n;
   logic [ID_W-1:0]   last_owner, last_owner_n;
   logic [ID_W-1:0]   grant_id_n;
   logic              write;
   logic              pick_found;
   logic [ID_W-1:0]   pick_id;
   logic [ID_W-1:0]   rr_id;
   int                rr_idx;
   logic [DATA_W-1:0] slice [NUM_REQ];

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_slice
         assign slice[g] = req_data[g*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search: the first requester after last_owner wins. The
   // loop walks from the farthest candidate to the nearest one, so the
   // nearest candidate is written last and takes priority.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      rr_idx     = 0;
      rr_id      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         rr_idx = (int'(last_owner) + k) % NUM_REQ;
         rr_id  = ID_W'(rr_idx);
         if (req[rr_id]) begin
            pick_found = 1'b1;
            pick_id    = rr_id;
         end
      end
   end

   // State register. A low rst drops any grant and returns the arbiter to IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= RESET_OWNER;
         grant_id   <= '0;
      end else begin
         state      <= state_n;
         burst_cnt  <= burst_cnt_n;
         last_owner <= last_owner_n;
         grant_id   <= grant_id_n;
      end
   end

   // Next-state logic and write decode. A write is gated by rst, so a reset
   // that arrives mid-burst never produces a partial word in the FIFO.
   always_comb begin
      state_n      = state;
      burst_cnt_n  = burst_cnt;
      last_owner_n = last_owner;
      grant_id_n   = grant_id;
      write        = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_id_n  = pick_id;
               burst_cnt_n = '0;
               state_n     = OWN;
            end
         end
         OWN: begin
            if (!req[grant_id]) begin
               state_n      = IDLE;
               last_owner_n = grant_id;
            end else if (!fifo_full) begin
               write       = rst;
               burst_cnt_n = burst_cnt + 1'b1;
               if (burst_cnt == LAST_BEAT) begin
                  state_n      = IDLE;
                  last_owner_n = grant_id;
                  burst_cnt_n  = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign fifo_w_en   = write;
   assign ack         = write ? (NUM_REQ'(1) << grant_id) : '0;
   assign fifo_data   = write ? slice[grant_id] : '0;
   assign grant_valid = (state == OWN) && rst;

endmodule
